aec_i2p: RTL

AEC_I2P -- requirements
Module: aec_i2p

---
 rtl/aec_pkg.sv | 81 ++++++++
 rtl/aec_char_fifo.sv | 78 +++++++
 rtl/aec_i2p.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aec_pkg
//  Description : Shared definitions for the infix-to-postfix converter:
//                operator codes, FSM state encoding, ASCII constants and the
//                character decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aec_pkg;

   // Operator codes as they appear on tok_data (upper two bits zero)
   localparam logic [1:0] c_OP_ADD  = 2'd0;
   localparam logic [1:0] c_OP_SUB  = 2'd1;
   localparam logic [1:0] c_OP_MUL  = 2'd2;
   localparam logic [1:0] c_OP_LPAR = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      CC_OPND = 3'd0,
      CC_OP   = 3'd1,
      CC_LPAR = 3'd2,
      CC_RPAR = 3'd3,
      CC_EQ   = 3'd4,
      CC_ILL  = 3'd5
   } char_cls_e;

   typedef struct packed {
      char_cls_e  cls;
      logic [3:0] val;   // operand value, or operator code in [1:0]
   } char_dec_t;

   localparam logic [7:0] c_ASCII_0     = 8'h30;
   localparam logic [7:0] c_ASCII_9     = 8'h39;
   localparam logic [7:0] c_ASCII_A     = 8'h61;   // lower-case 'a'
   localparam logic [7:0] c_ASCII_F     = 8'h66;   // lower-case 'f'
   localparam logic [7:0] c_ASCII_AOFS  = 8'h57;   // 'a' - 10
   localparam logic [7:0] c_ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] c_ASCII_MINUS = 8'h2D;
   localparam logic [7:0] c_ASCII_STAR  = 8'h2A;
   localparam logic [7:0] c_ASCII_LPAR  = 8'h28;
   localparam logic [7:0] c_ASCII_RPAR  = 8'h29;
   localparam logic [7:0] c_ASCII_EQ    = 8'h3D;

   // Classify one input character and extract its value / operator code
   function automatic char_dec_t decode_char(input logic [7:0] c);
      char_dec_t d;
      d.cls = CC_ILL;
      d.val = 4'd0;
      if (c >= c_ASCII_0 && c <= c_ASCII_9) begin
         d.cls = CC_OPND;
         d.val = c[3:0];
      end else if (c >= c_ASCII_A && c <= c_ASCII_F) begin
         d.cls = CC_OPND;
         d.val = 4'(c - c_ASCII_AOFS);
      end else begin
         case (c)
            c_ASCII_PLUS:  begin d.cls = CC_OP;   d.val = {2'b00, c_OP_ADD};  end
            c_ASCII_MINUS: begin d.cls = CC_OP;   d.val = {2'b00, c_OP_SUB};  end
            c_ASCII_STAR:  begin d.cls = CC_OP;   d.val = {2'b00, c_OP_MUL};  end
            c_ASCII_LPAR:  begin d.cls = CC_LPAR; d.val = {2'b00, c_OP_LPAR}; end
            c_ASCII_RPAR:  d.cls = CC_RPAR;
            c_ASCII_EQ:    d.cls = CC_EQ;
            default:       d.cls = CC_ILL;
         endcase
      end
      return d;
   endfunction

   // '*' binds tighter than '+' and '-'
   function automatic logic op_prec(input logic [1:0] op);
      return (op == c_OP_MUL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/aec_char_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : aec_char_fifo
//  Description : Synchronous character FIFO with show-ahead head output,
//                full/empty flags and a synchronous clear that may coincide
//                with a write (the write then lands as the first entry).
//  Revision    : 1.0 - initial release
// ============================================================================
module aec_char_fifo #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic             w_we;
   logic             w_re;
   logic [AW-1:0]    w_waddr;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_dout  = r_mem[r_rd_ptr];

   // A write while full is dropped so the pointers never overrun
   assign w_we    = i_wr && (i_clr || !o_full);
   assign w_re    = i_rd && !o_empty && !i_clr;
   assign w_waddr = i_clr ? '0 : r_wr_ptr;

   // Storage array; contents need no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= i_din;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= w_we ? AW'(1) : '0;
         r_count  <= w_we ? CW'(1) : '0;
      end else begin
         if (w_we) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_re) r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_we, w_re})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/aec_i2p.sv
`default_nettype none
// ============================================================================
//  Module      : aec_i2p
//  Description : Streaming infix-to-postfix converter (shunting-yard). One
//                ASCII character is captured per cycle into a FIFO; the FSM
//                drains it through an inline operator stack and emits one
//                postfix token per cycle.
//                Optional error detection: define AEC_I2P_ERR_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module aec_i2p #(
   parameter int MAX_LEN     = 32,
   parameter int STACK_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ready,
   input  logic [7:0] ascii_in,
   output logic       tok_valid,
   output logic       tok_is_op,
   output logic [3:0] tok_data,
   output logic       done,
   output logic       err
);

   import aec_pkg::*;

   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int SIW = $clog2(STACK_DEPTH);

   state_e         r_state;
   state_e         w_next;
   logic           r_cap;
   logic           w_cap;
   logic           w_abort;

   logic [7:0]     w_head;
   logic           w_fifo_full;
   logic           w_fifo_empty;
   logic           w_fifo_rd;
   char_dec_t      w_dec;

   logic [1:0]     r_stk [STACK_DEPTH];
   logic [SPW-1:0] r_sp;
   logic [1:0]     w_top;
   logic           w_stk_empty;
   logic           w_stk_full;
   logic           w_push;
   logic [1:0]     w_push_val;
   logic           w_pop;

   logic           w_tok_valid;
   logic           w_tok_is_op;
   logic [3:0]     w_tok_data;
   logic           w_done;

   // Capture runs from the ready cycle through the '=' character
   assign w_cap   = ready || r_cap;
   // ready outside IDLE restarts with the new character as the first one
   assign w_abort = ready && (r_state != IDLE);

   assign w_stk_empty = (r_sp == '0);
   assign w_stk_full  = (r_sp == SPW'(STACK_DEPTH));
   assign w_top       = r_stk[SIW'(r_sp - 1'b1)];
   assign w_dec       = decode_char(w_head);

   aec_char_fifo #(
      .DEPTH (MAX_LEN),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_abort),
      .i_wr    (w_cap && (!w_fifo_full || w_abort)),
      .i_din   (ascii_in),
      .i_rd    (w_fifo_rd),
      .o_dout  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // Capture-window flag: stays set until '=' has been written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_cap <= 1'b0;
      else     r_cap <= w_cap && (ascii_in != c_ASCII_EQ);
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Operator stack contents; the pointer alone defines validity
   always_ff @(posedge clk) begin
      if (w_push && !w_stk_full) begin
         r_stk[SIW'(r_sp)] <= w_push_val;
      end
   end

   // Operator stack pointer; saturates instead of wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         r_sp <= '0;
      else if (w_abort)                r_sp <= '0;
      else if (w_push && !w_stk_full)  r_sp <= r_sp + 1'b1;
      else if (w_pop && !w_stk_empty)  r_sp <= r_sp - 1'b1;
   end

   // Next state, single per-cycle action and token outputs
   always_comb begin
      w_next      = r_state;
      w_tok_valid = 1'b0;
      w_tok_is_op = 1'b0;
      w_tok_data  = 4'd0;
      w_done      = 1'b0;
      w_fifo_rd   = 1'b0;
      w_push      = 1'b0;
      w_push_val  = c_OP_ADD;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (ready) w_next = RUN;
         end
         RUN: begin
            if (!w_abort && !w_fifo_empty) begin
               case (w_dec.cls)
                  CC_OPND: begin
                     w_tok_valid = 1'b1;
                     w_tok_data  = w_dec.val;
                     w_fifo_rd   = 1'b1;
                  end
                  CC_LPAR: begin
                     w_push     = 1'b1;
                     w_push_val = c_OP_LPAR;
                     w_fifo_rd  = 1'b1;
                  end
                  CC_OP: begin
                     // Equal precedence also pops: left associativity
                     if (!w_stk_empty && (w_top != c_OP_LPAR) &&
                         (op_prec(w_top) >= op_prec(w_dec.val[1:0]))) begin
                        w_tok_valid = 1'b1;
                        w_tok_is_op = 1'b1;
                        w_tok_data  = {2'b00, w_top};
                        w_pop       = 1'b1;
                     end else begin
                        w_push     = 1'b1;
                        w_push_val = w_dec.val[1:0];
                        w_fifo_rd  = 1'b1;
                     end
                  end
                  CC_RPAR: begin
                     if (w_stk_empty) begin
                        w_fifo_rd = 1'b1;          // unmatched ')' is dropped
                     end else if (w_top == c_OP_LPAR) begin
                        w_pop     = 1'b1;          // matching '(' vanishes silently
                        w_fifo_rd = 1'b1;
                     end else begin
                        w_tok_valid = 1'b1;
                        w_tok_is_op = 1'b1;
                        w_tok_data  = {2'b00, w_top};
                        w_pop       = 1'b1;
                     end
                  end
                  CC_EQ: begin
                     w_fifo_rd = 1'b1;
                     w_next    = FLUSH;
                  end
                  default: begin
                     w_fifo_rd = 1'b1;             // illegal character ignored
                  end
               endcase
            end
         end
         FLUSH: begin
            if (w_abort) begin
               w_next = RUN;
            end else if (w_stk_empty) begin
               w_next = DONE;
            end else begin
               w_pop = 1'b1;
               if (w_top != c_OP_LPAR) begin
                  w_tok_valid = 1'b1;
                  w_tok_is_op = 1'b1;
                  w_tok_data  = {2'b00, w_top};
               end
            end
         end
         DONE: begin
            w_done = 1'b1;
            // A coincident ready has already started capturing a new expression
            w_next = ready ? RUN : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign tok_valid = w_tok_valid;
   assign tok_is_op = w_tok_is_op;
   assign tok_data  = w_tok_data;
   assign done      = w_done;

`ifdef AEC_I2P_ERR_CHECK_EN
   localparam int LW = $clog2(MAX_LEN + 1);

   logic [LW-1:0] r_len;
   logic          r_err;
   logic          w_len_ovf;
   logic          w_err_set;

   assign w_len_ovf = w_cap && !ready && (r_len >= LW'(MAX_LEN));

   assign w_err_set =
        ((r_state == RUN) && !w_abort && !w_fifo_empty &&
         ((w_dec.cls == CC_ILL) || ((w_dec.cls == CC_RPAR) && w_stk_empty)))
      || (w_push && w_stk_full)
      || ((r_state == FLUSH) && !w_abort && !w_stk_empty && (w_top == c_OP_LPAR))
      || w_len_ovf;

   // Characters captured so far in the current expression
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        r_len <= '0;
      else if (ready)                 r_len <= LW'(1);
      else if (w_cap && !w_len_ovf)   r_len <= r_len + 1'b1;
   end

   // Sticky error flag, reported alongside done and cleared per expression
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   r_err <= 1'b0;
      else if (ready)            r_err <= 1'b0;
      else if (r_state == DONE)  r_err <= 1'b0;
      else if (w_err_set)        r_err <= 1'b1;
   end

   assign err = w_done && r_err;
`else
   assign err = 1'b0;
`endif

endmodule
`default_nettype wire
